// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback wins, and a late
// multi-cycle result waits in a one-entry buffer until the port is free.
module regfile_wport_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_waddr,
  output logic              stall_req
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {EMPTY, PENDING, STARVED} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic [ADDR_W-1:0]   buf_addr_reg, buf_addr_next;
  logic [DATA_W-1:0]   buf_data_reg, buf_data_next;
  logic                pend, d_nz;
  logic                we_int;
  logic [ADDR_W-1:0]   waddr_int;
  logic [DATA_W-1:0]   wdata_int;

  assign pend    = (state_reg != EMPTY);
  assign d_nz    = (d_waddr != '0);
  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    buf_addr_next = buf_addr_reg;
    buf_data_next = buf_data_reg;
    we_int        = 1'b0;
    waddr_int     = '0;
    wdata_int     = '0;
    if (p_we) begin
      if (p_waddr != '0) begin
        we_int    = 1'b1;
        waddr_int = p_waddr;
        wdata_int = p_wdata;
      end
      if (pend) begin
        // A younger pipeline write to the same register makes the pending result dead.
        if (buf_addr_reg == p_waddr) begin
          state_next = EMPTY;
          cnt_next   = '0;
        end else if (state_reg == PENDING) begin
          if (cnt_inc >= CNT_W'(STARVE_LIMIT)) begin
            state_next = STARVED;
            cnt_next   = CNT_W'(STARVE_LIMIT);
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end else if (d_valid && d_nz && (d_waddr != p_waddr)) begin
        state_next    = PENDING;
        cnt_next      = '0;
        buf_addr_next = d_waddr;
        buf_data_next = d_wdata;
      end
    end else begin
      if (pend) begin
        we_int    = 1'b1;
        waddr_int = buf_addr_reg;
        wdata_int = buf_data_reg;
        cnt_next  = '0;
        if (d_valid && d_nz) begin
          state_next    = PENDING;
          buf_addr_next = d_waddr;
          buf_data_next = d_wdata;
        end else begin
          state_next = EMPTY;
        end
      end else if (d_valid && d_nz) begin
        we_int    = 1'b1;
        waddr_int = d_waddr;
        wdata_int = d_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      cnt_reg      <= '0;
      buf_addr_reg <= '0;
      buf_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      buf_addr_reg <= buf_addr_next;
      buf_data_reg <= buf_data_next;
    end
  end

  // Every output is forced low while reset is held, even before the reset edge.
  assign d_ready    = !rst && (!pend || !p_we);
  assign rf_we      = !rst && we_int;
  assign rf_waddr   = rst ? '0 : waddr_int;
  assign rf_wdata   = rst ? '0 : wdata_int;
  assign pend_valid = !rst && pend;
  assign pend_waddr = (!rst && pend) ? buf_addr_reg : '0;
  assign stall_req  = !rst && (state_reg == STARVED);

endmodule
